uart_tx: RTL and testbench
==========================

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 27_000_000, meaning: clk frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, meaning: line bit rate.
REQ-003 Parameter FIFO_DEPTH_BITWIDTH, default 4, meaning: transmit FIFO holds 2^FIFO_DEPTH_BITWIDTH bytes.
REQ-004 clk  input  1  sole clock; all state SHALL change on its rising edge, except on reset.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 wr_data  input  8  byte to enqueue.
REQ-007 wr_en  input  1  1: wr_data is valid this cycle, single-cycle strobe per byte.
REQ-008 full  output  1  1: FIFO full; a write this cycle is dropped.
REQ-009 busy  output  1  1: FSM not IDLE or FIFO not empty.
REQ-010 overflow  output  1  sticky; 1: at least one write was dropped since reset.
REQ-011 tx  output  1  serial line, idle high, registered output.

Function
REQ-012 CLKS_PER_BIT SHALL be CLK_FREQ/BAUD_RATE using integer truncation, giving 234 at the defaults.
REQ-013 Frame format SHALL be 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1).
REQ-014 Each bit SHALL be held for exactly CLKS_PER_BIT cycles, so a frame lasts 10*CLKS_PER_BIT cycles.
REQ-015 FSM states SHALL be IDLE, START, DATA, STOP.
- IDLE->START when FIFO not empty: pop, load shift register, tx<=0.
- START->DATA after CLKS_PER_BIT cycles.
- DATA->STOP after 8 bit times; a 3-bit index counts 0..7.
- STOP->START directly if FIFO not empty at the end of the stop bit (back-to-back, no idle gap); else STOP->IDLE.
REQ-016 Latency: for a write accepted at rising edge N into an empty FIFO with the FSM in IDLE, tx SHALL fall at edge N+2.
REQ-017 A write SHALL be accepted iff wr_en=1 and full=0 (full taken from registered occupancy).
REQ-018 A write while full=1 SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle.
REQ-019 A simultaneous accepted write and pop SHALL leave occupancy unchanged; data order SHALL be strict FIFO.
REQ-020 FIFO pointers SHALL wrap modulo 2^FIFO_DEPTH_BITWIDTH.
REQ-021 Occupancy SHALL be FIFO_DEPTH_BITWIDTH+1 bits wide; full when it equals 2^FIFO_DEPTH_BITWIDTH.
REQ-022 The bit-time counter SHALL be $clog2(CLKS_PER_BIT) bits wide and restart at 0 on every bit boundary.
REQ-023 busy SHALL drop to 0 in the same cycle the FSM enters IDLE with an empty FIFO.

Reset
REQ-024 While rst_n=0: tx=1, full=0, busy=0, overflow=0, FSM=IDLE, FIFO empty, all counters 0; asserted asynchronously.
REQ-025 Reset mid-frame SHALL abort the frame immediately (tx high) and discard all queued bytes.
REQ-026 Deassertion SHALL be treated as synchronous to clk; the first write is accepted at the first edge after release.

Structure
REQ-027 Shared package uart_pkg SHALL hold the FSM state encoding and the frame constants: data bits 8, frame bits 10.
REQ-028 One sub-module, fifo (synchronous, parameterised by width and depth bitwidth), SHALL implement the queue.
REQ-029 All remaining logic (FSM, bit timer, shift register) SHALL reside in uart_tx.

Verification (bench runs with CLK_FREQ=10, BAUD_RATE=1, so CLKS_PER_BIT=10, unless noted)
REQ-030 Write 0xA5 once -> tx low at N+2 for 10 cycles, then bits 1,0,1,0,0,1,0,1 at 10 cycles each, then high 10 cycles; busy=0 after; total frame 100 cycles.
REQ-031 Write 0x00, 0xFF, 0x3C on consecutive cycles -> three contiguous frames (300 cycles), no idle gap, correct order.
REQ-032 Write 18 bytes back-to-back -> full=1 after 16 queued (minus 1 popped at N+2), last excess write dropped, overflow=1, received bytes equal the accepted ones in order.
REQ-033 Write while full in the same cycle as a pop -> byte dropped, overflow=1, occupancy decrements by 1.
REQ-034 Assert rst_n=0 mid DATA bit 3 of 0x81 with 4 bytes queued -> tx=1 immediately, busy=0, full=0, overflow=0; after release no frame is sent until a new write.
REQ-035 Defaults (27 MHz, 115200) -> each bit measures 234 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, frame constants
// and the line level driven in each state.
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned FRAME_BITS = 10;

  // Level the serial line must carry while the FSM sits in a given state.
  function automatic logic line_level(input uart_state_e state, input logic data_bit);
    logic level;
    case (state)
      ST_START: level = 1'b0;
      ST_DATA:  level = data_bit;
      ST_STOP:  level = 1'b1;
      default:  level = 1'b1;
    endcase
    return level;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Write-side and status bundle of the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_en;
  logic                 full;
  logic                 busy;
  logic                 overflow;
  logic                 tx;

  modport master (output wr_data, output wr_en,
                  input full, input busy, input overflow, input tx);
  modport slave  (input wr_data, input wr_en,
                  output full, output busy, output overflow, output tx);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous show-ahead FIFO with registered occupancy and a sticky flag
// for writes dropped while full.
module fifo #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DEPTH_BW = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_overflow
);

  localparam int unsigned      DEPTH    = 1 << DEPTH_BW;
  localparam logic [DEPTH_BW:0] FULL_CNT = (DEPTH_BW + 1)'(DEPTH);

  logic [WIDTH-1:0]    r_mem [DEPTH];
  logic [DEPTH_BW-1:0] r_wr_ptr;
  logic [DEPTH_BW-1:0] r_rd_ptr;
  logic [DEPTH_BW:0]   r_count;
  logic                r_overflow;
  logic                w_full;
  logic                w_empty;
  logic                w_wr_acc;
  logic                w_rd_acc;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  // Full is judged on the registered count, so a same-cycle pop never rescues a write.
  assign w_wr_acc = i_wr_en & ~w_full;
  assign w_rd_acc = i_rd_en & ~w_empty;

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + DEPTH_BW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + DEPTH_BW'(1);
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + (DEPTH_BW + 1)'(1);
        2'b01:   r_count <= r_count - (DEPTH_BW + 1)'(1);
        default: r_count <= r_count;
      endcase
      if (i_wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign o_rd_data  = r_mem[r_rd_ptr];
  assign o_full     = w_full;
  assign o_empty    = w_empty;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter fed by a byte FIFO; frames are sent back-to-back
// while the FIFO holds data.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ            = 27_000_000,
  parameter int unsigned BAUD_RATE           = 115200,
  parameter int unsigned FIFO_DEPTH_BITWIDTH = 4
) (
  input logic      clk,
  input logic      rst_n,
  uart_tx_if.slave bus
);

  localparam int unsigned       CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int unsigned       CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0]  LAST_CNT     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]        LAST_IDX     = 3'(DATA_BITS - 1);

  uart_state_e          r_state;
  uart_state_e          w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [2:0]           r_bit_idx;
  logic [2:0]           w_bit_idx_nxt;
  logic [DATA_BITS-1:0] r_shift;
  logic [DATA_BITS-1:0] w_shift_nxt;
  logic                 r_tx;
  logic                 w_pop;
  logic                 w_bit_done;
  logic [DATA_BITS-1:0] w_rd_data;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_overflow;

  fifo #(
    .WIDTH    (DATA_BITS),
    .DEPTH_BW (FIFO_DEPTH_BITWIDTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_wr_en    (bus.wr_en),
    .i_wr_data  (bus.wr_data),
    .i_rd_en    (w_pop),
    .o_rd_data  (w_rd_data),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_overflow (w_overflow)
  );

  assign w_bit_done = (r_cnt == LAST_CNT);

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = w_bit_done ? '0 : r_cnt + CNT_W'(1);
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_pop         = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cnt_nxt = '0;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rd_data;
          w_state_nxt = ST_START;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_bit_done) begin
          w_bit_idx_nxt = '0;
          w_state_nxt   = ST_DATA;
        end else begin
          w_state_nxt = ST_START;
        end
      end
      ST_DATA: begin
        if (w_bit_done) begin
          w_shift_nxt   = r_shift >> 1;
          w_bit_idx_nxt = r_bit_idx + 3'd1;
          w_state_nxt   = (r_bit_idx == LAST_IDX) ? ST_STOP : ST_DATA;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_STOP: begin
        // Chain straight into the next start bit when more data is waiting.
        if (w_bit_done && !w_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rd_data;
          w_state_nxt = ST_START;
        end else if (w_bit_done) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_STOP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_tx      <= line_level(r_state, r_shift[0]);
    end
  end

  assign bus.tx       = r_tx;
  assign bus.full     = w_full;
  assign bus.overflow = w_overflow;
  assign bus.busy     = (r_state != ST_IDLE) | ~w_empty;

endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model compared every
// cycle, a line receiver, and directed scenarios with literal expectations.
module tb_uart_tx;

  localparam int CPB   = 10;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  uart_tx_if bus();
  uart_tx_if bus_def();

  uart_tx #(.CLK_FREQ(10), .BAUD_RATE(1), .FIFO_DEPTH_BITWIDTH(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  uart_tx u_dut_def (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_def)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic fbit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    else if (idx <= 8) return b[idx-1];
    else return 1'b1;
  endfunction

  // Reference model: byte queue plus frame timeline; line is seen one cycle later.
  logic [7:0] mq[$];
  logic [7:0] sent[$];
  bit         m_sending = 1'b0;
  int         m_c = 0;
  int         m_pre = 0;
  bit         m_pop = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic       m_line = 1'b1;
  logic       m_tx = 1'b1;
  logic       m_ovf = 1'b0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      sent.delete();
      m_sending = 1'b0;
      m_c = 0;
      m_line = 1'b1;
      m_tx = 1'b1;
      m_ovf = 1'b0;
    end else begin
      m_tx  = m_line;
      m_pre = mq.size();
      m_pop = 1'b0;
      if (m_sending) begin
        m_c++;
        if (m_c == 10 * CPB) begin
          if (m_pre > 0) m_pop = 1'b1;
          else m_sending = 1'b0;
        end
      end else if (m_pre > 0) begin
        m_pop = 1'b1;
      end
      if (m_pop) begin
        m_byte = mq.pop_front();
        sent.push_back(m_byte);
        m_sending = 1'b1;
        m_c = 0;
      end
      if (bus.wr_en === 1'b1) begin
        if (m_pre < DEPTH) mq.push_back(bus.wr_data);
        else m_ovf = 1'b1;
      end
      m_line = m_sending ? fbit(m_byte, m_c / CPB) : 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    chk("tx", bus.tx, m_tx);
    chk("busy", bus.busy, m_sending || (mq.size() > 0));
    chk("full", bus.full, mq.size() == DEPTH);
    chk("overflow", bus.overflow, m_ovf);
  end

  // Line receiver: samples mid-bit and checks order against what the model popped.
  int         rx_c = 0;
  logic [7:0] rx_sh = 8'h00;
  logic [7:0] rx_log[$];

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      rx_c = 0;
    end else if (rx_c == 0) begin
      if (bus.tx === 1'b0) rx_c = 1;
    end else begin
      if (rx_c % CPB == CPB / 2) begin
        if (rx_c / CPB >= 1 && rx_c / CPB <= 8) begin
          rx_sh[rx_c / CPB - 1] = bus.tx;
        end else if (rx_c / CPB == 9) begin
          chk("rx_stop", bus.tx, 1'b1);
          if (sent.size() == 0) chk("rx_unexpected_frame", 32'd1, 32'd0);
          else chk("rx_order", rx_sh, sent.pop_front());
          rx_log.push_back(rx_sh);
        end
      end
      rx_c = (rx_c / CPB == 9 && rx_c % CPB == CPB / 2) ? 0 : rx_c + 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
  endtask

  logic [9:0] frame_a5;
  int         lo;
  int         hi;
  int         w;

  initial begin
    bus.wr_en = 1'b0;
    bus.wr_data = 8'h00;
    bus_def.wr_en = 1'b0;
    bus_def.wr_data = 8'h00;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    idle(3);
    chk("reset_tx", bus.tx, 1'b1);
    chk("reset_busy", bus.busy, 1'b0);

    // Single 0xA5 frame; write accepted at the first edge after release.
    frame_a5 = {1'b1, 8'hA5, 1'b0};
    rst_n = 1'b1;
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hA5;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("a5_tx_n", bus.tx, 1'b1);
    idle(1);
    chk("a5_tx_n1", bus.tx, 1'b1);
    idle(1);
    for (int k = 0; k < 10; k++) begin
      chk("a5_bit_first", bus.tx, frame_a5[k]);
      if (k == 9) chk("a5_busy_stop", bus.busy, 1'b1);
      idle(9);
      chk("a5_bit_last", bus.tx, frame_a5[k]);
      if (k == 9) chk("a5_busy_done", bus.busy, 1'b0);
      idle(1);
    end
    chk("a5_rx_count", rx_log.size(), 32'd1);
    chk("a5_rx_byte", rx_log[0], 8'hA5);

    // Three back-to-back frames with no idle gap.
    idle(5);
    rx_log.delete();
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h00;
    @(negedge clk);
    bus.wr_data = 8'hFF;
    @(negedge clk);
    bus.wr_data = 8'h3C;
    @(negedge clk);
    bus.wr_en = 1'b0;
    idle(99);
    chk("b2b_stop1", bus.tx, 1'b1);
    idle(1);
    chk("b2b_start2", bus.tx, 1'b0);
    idle(100);
    chk("b2b_start3", bus.tx, 1'b0);
    idle(99);
    chk("b2b_busy_done", bus.busy, 1'b0);
    chk("b2b_rx_count", rx_log.size(), 32'd3);
    chk("b2b_rx0", rx_log[0], 8'h00);
    chk("b2b_rx1", rx_log[1], 8'hFF);
    chk("b2b_rx2", rx_log[2], 8'h3C);

    // Eighteen writes in a row: fills, drops the last one, sets overflow.
    idle(5);
    rx_log.delete();
    for (int i = 0; i < 18; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'h10 + 8'(i);
      @(negedge clk);
      if (i == 15) chk("fill_not_full", bus.full, 1'b0);
      if (i == 16) begin
        chk("fill_full", bus.full, 1'b1);
        chk("fill_no_ovf", bus.overflow, 1'b0);
      end
      if (i == 17) chk("fill_ovf", bus.overflow, 1'b1);
    end
    bus.wr_en = 1'b0;
    idle(1750);
    chk("fill_rx_count", rx_log.size(), 32'd17);
    chk("fill_rx_first", rx_log[0], 8'h10);
    chk("fill_rx_last", rx_log[16], 8'h20);
    chk("fill_ovf_sticky", bus.overflow, 1'b1);

    // Write while full on the very cycle the next byte is popped.
    pulse_reset();
    for (int i = 0; i < 17; i++) begin
      bus.wr_en = 1'b1;
      bus.wr_data = 8'h40 + 8'(i);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    idle(84);
    chk("pop_full_before", bus.full, 1'b1);
    chk("pop_ovf_before", bus.overflow, 1'b0);
    bus.wr_en = 1'b1;
    bus.wr_data = 8'hEE;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("pop_ovf_after", bus.overflow, 1'b1);
    chk("pop_full_after", bus.full, 1'b0);

    // Reset in the middle of data bit 3 of 0x81 with four bytes queued.
    pulse_reset();
    rx_log.delete();
    bus.wr_en = 1'b1;
    bus.wr_data = 8'h81;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      bus.wr_data = 8'h90 + 8'(i);
      @(negedge clk);
    end
    bus.wr_en = 1'b0;
    idle(41);
    chk("mid_bit3_low", bus.tx, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", bus.tx, 1'b1);
    chk("mid_rst_busy", bus.busy, 1'b0);
    chk("mid_rst_full", bus.full, 1'b0);
    chk("mid_rst_ovf", bus.overflow, 1'b0);
    idle(2);
    rst_n = 1'b1;
    idle(150);
    chk("post_rst_tx", bus.tx, 1'b1);
    chk("post_rst_busy", bus.busy, 1'b0);
    chk("post_rst_rx", rx_log.size(), 32'd0);

    // Default parameters: each bit lasts 234 cycles.
    bus_def.wr_en = 1'b1;
    bus_def.wr_data = 8'h01;
    @(negedge clk);
    bus_def.wr_en = 1'b0;
    w = 0;
    while (bus_def.tx === 1'b1 && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("def_start_seen", bus_def.tx, 1'b0);
    lo = 0;
    while (bus_def.tx === 1'b0 && lo < 500) begin
      lo++;
      @(negedge clk);
    end
    chk("def_start_len", lo, 32'd234);
    hi = 0;
    while (bus_def.tx === 1'b1 && hi < 500) begin
      hi++;
      @(negedge clk);
    end
    chk("def_bit0_len", hi, 32'd234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
